// File: rtl/ethernet_package.sv
// rtl/ethernet_package.sv - shared constants and state encoding for the transmit path
package ethernet_package;

    localparam int ETHERNET_MINIMUM_FRAME_BYTES = 60;

    typedef enum logic {
        PASS = 1'b0,
        PAD  = 1'b1
    } padder_state_t;

endpackage

// File: rtl/ethernet_frame_padder.sv
// rtl/ethernet_frame_padder.sv - pads short frames to the minimum length ahead of FCS generation
module ethernet_frame_padder
    import ethernet_package::*;
#(
    parameter int         MINIMUM_FRAME_BYTES = ETHERNET_MINIMUM_FRAME_BYTES,
    parameter logic [7:0] PAD_BYTE            = 8'h00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  slave_data,
    input  logic        slave_valid,
    input  logic        slave_last,
    output logic        slave_ready,
    output logic [7:0]  master_data,
    output logic        master_valid,
    output logic        master_last,
    input  logic        master_ready,
    output logic        padded_frame,
    output logic [15:0] padded_frame_count
);

    localparam logic [11:0] MIN_BYTES = 12'(MINIMUM_FRAME_BYTES);

    padder_state_t r_state;
    padder_state_t w_next_state;
    logic [10:0]   r_byte_count;
    logic [10:0]   w_next_byte_count;
    logic [7:0]    r_master_data;
    logic [7:0]    w_next_data;
    logic          r_master_valid;
    logic          w_next_valid;
    logic          r_master_last;
    logic          w_next_last;
    logic          r_padded_frame;
    logic          w_next_padded_frame;
    logic [15:0]   r_padded_frame_count;
    logic [15:0]   w_next_padded_frame_count;

    logic          w_free;
    logic          w_slave_xfer;
    logic [11:0]   w_count_plus_one;
    logic [10:0]   w_count_saturated;

    assign w_free            = !r_master_valid || master_ready;
    assign slave_ready       = (r_state == PASS) && w_free && !reset;
    assign w_slave_xfer      = slave_valid && slave_ready;
    // Widened so the length test stays correct once the counter has saturated.
    assign w_count_plus_one  = {1'b0, r_byte_count} + 12'd1;
    assign w_count_saturated = (r_byte_count == 11'h7FF) ? r_byte_count : w_count_plus_one[10:0];

    always_comb begin
        w_next_state              = r_state;
        w_next_byte_count         = r_byte_count;
        w_next_data               = r_master_data;
        w_next_valid              = r_master_valid;
        w_next_last               = r_master_last;
        w_next_padded_frame       = 1'b0;
        w_next_padded_frame_count = r_padded_frame_count;

        case (r_state)
            PASS: begin
                if (w_slave_xfer) begin
                    w_next_data  = slave_data;
                    w_next_valid = 1'b1;
                    w_next_last  = 1'b0;
                    if (slave_last && (w_count_plus_one >= MIN_BYTES)) begin
                        w_next_last       = 1'b1;
                        w_next_byte_count = 11'd0;
                    end else if (slave_last) begin
                        w_next_byte_count         = w_count_saturated;
                        w_next_padded_frame       = 1'b1;
                        w_next_padded_frame_count = r_padded_frame_count + 16'd1;
                        w_next_state              = PAD;
                    end else begin
                        w_next_byte_count = w_count_saturated;
                    end
                end else if (w_free) begin
                    w_next_valid = 1'b0;
                    w_next_last  = 1'b0;
                end
            end
            PAD: begin
                if (w_free) begin
                    w_next_data  = PAD_BYTE;
                    w_next_valid = 1'b1;
                    if (w_count_plus_one == MIN_BYTES) begin
                        w_next_last       = 1'b1;
                        w_next_byte_count = 11'd0;
                        w_next_state      = PASS;
                    end else begin
                        w_next_last       = 1'b0;
                        w_next_byte_count = w_count_saturated;
                    end
                end
            end
            default: w_next_state = PASS;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state              <= PASS;
            r_byte_count         <= 11'd0;
            r_master_data        <= 8'h00;
            r_master_valid       <= 1'b0;
            r_master_last        <= 1'b0;
            r_padded_frame       <= 1'b0;
            r_padded_frame_count <= 16'd0;
        end else begin
            r_state              <= w_next_state;
            r_byte_count         <= w_next_byte_count;
            r_master_data        <= w_next_data;
            r_master_valid       <= w_next_valid;
            r_master_last        <= w_next_last;
            r_padded_frame       <= w_next_padded_frame;
            r_padded_frame_count <= w_next_padded_frame_count;
        end
    end

    assign master_data        = r_master_data;
    assign master_valid       = r_master_valid;
    assign master_last        = r_master_last;
    assign padded_frame       = r_padded_frame;
    assign padded_frame_count = r_padded_frame_count;

endmodule

// File: doc/ethernet_frame_padder.md
# ethernet_frame_padder

Byte-stream stage directly upstream of `frame_check_sequence_generator` on the switch transmit path. It forwards each outgoing Ethernet frame (destination MAC through payload, no FCS) and, when the frame is shorter than the minimum, appends pad bytes until it reaches `MINIMUM_FRAME_BYTES`. The FCS is therefore computed over a legal-length frame. Frames at or above the minimum pass through byte-for-byte with one cycle of latency.

## Interface
- `MINIMUM_FRAME_BYTES`, default 60: minimum pre-FCS frame length, in bytes; range 2..2047.
- `PAD_BYTE`, default 8'h00: value used for every inserted byte.
- `clock`  input  1: single clock; all logic is on the rising edge.
- `reset`  input  1: asynchronous, active-high reset.
- `slave_data`  input  8: incoming frame byte.
- `slave_valid`  input  1: `slave_data`/`slave_last` are valid.
- `slave_last`  input  1: the current byte is the final byte of the frame.
- `slave_ready`  output  1: the block accepts the byte this cycle.
- `master_data`  output  8: outgoing byte to the FCS generator.
- `master_valid`  output  1: `master_data`/`master_last` are valid.
- `master_last`  output  1: final byte of the (padded) frame.
- `master_ready`  input  1: the downstream stage accepts this cycle.
- `padded_frame`  output  1: one-cycle pulse when a frame is found to need padding.
- `padded_frame_count`  output  16: running count of padded frames; wraps at 16'hFFFF→0.

## Operation
- Transfers: a slave transfer occurs when `slave_valid && slave_ready`; a master transfer occurs when `master_valid && master_ready`.
- Output register: `master_data/valid/last` are registered. The register is "free" when `!master_valid || master_ready`.
- The state machine has two states, PASS (reset state) and PAD.
- PASS:
  - `slave_ready = free` (combinational), forced to 0 while `reset` is high.
  - On a slave transfer, the byte is loaded into the output register and `byte_count` increments.
  - If `slave_last` is set and `byte_count+1 >= MINIMUM_FRAME_BYTES`:
    - `master_last` is set to 1.
    - `byte_count` clears to 0.
    - The state stays PASS.
  - If `slave_last` is set and `byte_count+1 < MINIMUM_FRAME_BYTES`:
    - `master_last` is set to 0.
    - `padded_frame` pulses.
    - `padded_frame_count` increments.
    - The state goes to PAD.
- PAD:
  - `slave_ready = 0`.
  - Each cycle the register is free, `PAD_BYTE` is loaded and `byte_count` increments.
  - When `byte_count+1 == MINIMUM_FRAME_BYTES`, the byte is loaded with `master_last=1`, `byte_count` clears to 0, and the state goes to PASS.
- `byte_count` is 11 bits and saturates at 2047 on long frames. Only comparison against the minimum matters.
- Frames longer than the minimum are never truncated or altered.

## Timing
- Reset values: `master_data=8'h00`, `master_valid=0`, `master_last=0`, `padded_frame=0`, `padded_frame_count=0`, `byte_count=0`, state PASS.
- Latency: one cycle from slave transfer to `master_valid`.
- Throughput: one byte per cycle with `master_ready` held high. Padding also runs at one byte per cycle.
- A frame of N < MIN bytes occupies exactly MIN output cycles with no gaps under no backpressure.
- The next frame's first byte is accepted in the same cycle the padded last byte is transferred, because PASS is re-entered and the register is free.
- Master signals hold stable while `master_valid && !master_ready`. `byte_count` does not advance while stalled.
- `padded_frame` is registered. It asserts in the cycle after the short `slave_last` transfer, concurrent with `master_valid` for that byte.
- Reset asserted mid-frame or mid-pad:
  - Outputs return to their reset values immediately (asynchronously).
  - The partial frame is discarded; no `master_last` is emitted for it.

## Structure
- Shared package `ethernet_package` holds:
  - the constant `ETHERNET_MINIMUM_FRAME_BYTES = 60`, used as the parameter default;
  - the enum `padder_state_t {PASS, PAD}`.
- Single module, no sub-module. The state, counter and output register are small enough to remain flat.

## Test plan
- 1-byte frame 8'hAA, `master_ready=1`:
  - Output is AA followed by 59 bytes of 00.
  - `master_last` is high only on the 60th byte.
  - `padded_frame` pulses once; `padded_frame_count=1`.
- 60-byte frame with data 0..59:
  - Output is identical, `last` on byte 60.
  - No `padded_frame`; count unchanged.
- 61-byte frame:
  - Output is identical, `last` on byte 61, no padding.
- 10-byte frame with `master_ready` toggled 1/0 every cycle during padding:
  - Exactly 60 bytes transfer.
  - Data and `last` are stable through stalls.
  - `slave_ready` stays low until the 60th transfer.
- Back-to-back frames (20 bytes, then 70 bytes), `slave_valid` held high:
  - Output is 60 + 70 bytes with no idle cycle between frames.
  - `padded_frame_count=1`.
- Reset pulsed at pad byte 30 of a 5-byte frame:
  - `master_valid` drops immediately; count returns to 0.
  - A subsequent 5-byte frame pads correctly to 60 bytes.
